muldiv_seq_ctrl: RTL and testbench
==================================

Name: muldiv_seq_ctrl

Overview:
Iterative multiply/divide sequencer for the MIPS pipeline's HI/LO resource. It accepts MULT/MULTU/DIV/DIVU from the EX stage and runs a radix-2 shift-add multiply or restoring divide over DATA_W cycles. While busy it raises a pipeline stall for any instruction in ID that reads or writes HI/LO. It then writes HI and LO together in one cycle.

Parameters:
DATA_W, 32, operand width; HI/LO each DATA_W bits; iteration count = DATA_W.

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous active-high reset
start  in  1  EX holds a muldiv instruction; sampled only in IDLE
op  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
src_a  in  DATA_W  rs operand (multiplicand / dividend)
src_b  in  DATA_W  rt operand (multiplier / divisor)
flush  in  1  exception/eret flush; cancels the operation in progress
hilo_use_id  in  1  ID instruction reads or writes HI/LO (MFHI/MFLO/MTHI/MTLO/muldiv)
busy  out  1  state != IDLE
stall_req  out  1  stall IF/ID
hilo_we  out  1  one-cycle HI+LO write strobe
hi_out  out  DATA_W  HI result (MULT: product[63:32]; DIV: remainder)
lo_out  out  DATA_W  LO result (MULT: product[31:0]; DIV: quotient)

Behaviour:
- States: IDLE, CALC, FIX, DONE. Reset forces IDLE, counter=0, hi_out=lo_out=0, and busy/stall_req/hilo_we=0. Reset applies mid-operation, and no write follows it.
- IDLE, start=1, flush=0, at clock edge E0:
  - Latch |src_a| and |src_b|. Absolute values apply for signed ops only; 0x80000000 stays 0x80000000 as unsigned.
  - Latch the result signs: sign_q = a[31]^b[31] and sign_r = a[31], for signed ops only.
  - Clear the accumulator and counter, then go to CALC.
- Divide by zero (op[1]=1 and src_b=0) goes straight to DONE instead. It loads hi_out=src_a and lo_out={DATA_W{1}}.
- CALC: one iteration per cycle, counter 0..DATA_W-1.
  - Multiply: if the multiplier LSB is set, add the multiplicand to the upper half. Then shift the 2*DATA_W accumulator right by 1.
  - Divide: shift {rem,quo} left by 1. Trial-subtract the divisor. If the result is non-negative, keep it and set the quotient LSB.
  - At counter=DATA_W-1, go to FIX.
- FIX (1 cycle): signed ops fix the result signs.
  - Multiply: negate the 64-bit product if sign_q.
  - Divide: negate the quotient if sign_q, and negate the remainder if sign_r.
  - Load hi_out/lo_out, then go to DONE.
  - -2^31 / -1 wraps: lo=0x80000000, hi=0.
- DONE (1 cycle): hilo_we = !flush, then go to IDLE. The HI/LO regfile captures the result at the edge leaving DONE.
- Latency: start at E0 gives 32 CALC edges (E1..E32), FIX→DONE at E33, and the HI/LO write at E34. Divide by zero writes at E1.
- flush has priority in every state. In CALC or FIX it goes to IDLE next edge with hi_out/lo_out unchanged. In DONE it suppresses hilo_we. In IDLE it blocks start.
- stall_req = busy & (hilo_use_id | start). It stays high through DONE and drops the cycle the FSM is back in IDLE.
- start while busy is ignored. It stays held by stall_req and is re-sampled in IDLE, so back-to-back ops run with one IDLE cycle between them.
- hi_out/lo_out hold their last written values while idle.

Optional Feature:
MULDIV_EARLY_OUT_EN
- Defined: in multiply CALC, when the remaining unshifted multiplier bits are all zero, shift the accumulator right by the remaining count in one step and go to FIX. Results are identical; only latency shrinks, with a minimum of E2 for FIX→DONE when src_b=0.
- Undefined: fixed 32-iteration latency for all ops.

Test Plan:
- MULTU 0xFFFFFFFF×0xFFFFFFFF, start at E0 → hilo_we high only in the cycle before E34; hi=0xFFFFFFFE, lo=0x00000001.
- MULT -3×5 → hi=0xFFFFFFFF, lo=0xFFFFFFF1. DIV -7/2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIV 0x80000000/0xFFFFFFFF → lo=0x80000000, hi=0.
- DIVU 100/0 → DONE after E0; hilo_we high before E1; hi=0x64, lo=0xFFFFFFFF.
- MULT started, then flush at E10 → busy=0 after E11, hilo_we never asserts, hi/lo keep their prior values. Repeat with flush in DONE → hilo_we stays 0.
- During CALC with hilo_use_id=1 → stall_req=1 through DONE and 0 in the next IDLE cycle. With hilo_use_id=0 and start=0 → stall_req=0 while busy.
- rst at E5 of a DIV → IDLE, all outputs 0 at E6, no write. With MULDIV_EARLY_OUT_EN, MULTU 7×3 → write at E5 with lo=21 and hi=0.

Source files
------------

// File: rtl/muldiv_seq_ctrl.sv
// muldiv_seq_ctrl: iterative multiply/divide sequencer for the HI/LO unit.
// Radix-2 shift-add multiply and restoring divide run one bit per cycle.
// Signed operands are converted to magnitudes on entry, and the result signs
// are fixed up in a single FIX cycle. HI and LO are written together with a
// one-cycle strobe from DONE.
// Optional feature macro: MULDIV_EARLY_OUT_EN. When it is defined, a multiply
// ends early once the remaining multiplier bits are all zero.
module muldiv_seq_ctrl #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [1:0]        op,
    input  logic [DATA_W-1:0] src_a,
    input  logic [DATA_W-1:0] src_b,
    input  logic              flush,
    input  logic              hilo_use_id,
    output logic              busy,
    output logic              stall_req,
    output logic              hilo_we,
    output logic [DATA_W-1:0] hi_out,
    output logic [DATA_W-1:0] lo_out
);

    localparam int CNT_W = $clog2(DATA_W + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    // Multiply: {upper partial product, lower product / remaining multiplier}
    // Divide:   {remainder, quotient / remaining dividend}
    logic [2*DATA_W-1:0] acc_q, acc_d;
    logic [DATA_W-1:0]   opnd_q, opnd_d;    // multiplicand or divisor magnitude
    logic                is_div_q, is_div_d;
    logic                neg_quo_q, neg_quo_d;  // negate product / quotient
    logic                neg_rem_q, neg_rem_d;  // negate remainder
    logic [DATA_W-1:0]   hi_q, hi_d;
    logic [DATA_W-1:0]   lo_q, lo_d;
    logic                we;

    // Operand magnitudes. Only the signed ops (op[0]=0) take absolute values.
    // The most negative value maps onto itself, which is the correct unsigned
    // magnitude.
    logic                signed_op;
    logic [DATA_W-1:0]   abs_a, abs_b;
    assign signed_op = ~op[0];
    assign abs_a = (signed_op && src_a[DATA_W-1]) ? -src_a : src_a;
    assign abs_b = (signed_op && src_b[DATA_W-1]) ? -src_b : src_b;

    // Multiply step: add the multiplicand to the upper half when the
    // multiplier LSB is set, then shift the whole accumulator right by one.
    // The carry out of the add becomes the new MSB.
    logic [DATA_W:0]     msum;
    logic [2*DATA_W-1:0] mul_next;
    assign msum     = {1'b0, acc_q[2*DATA_W-1:DATA_W]}
                    + (acc_q[0] ? {1'b0, opnd_q} : {(DATA_W+1){1'b0}});
    assign mul_next = {msum, acc_q[DATA_W-1:1]};

    // Divide step: shift {rem,quo} left by one, then trial-subtract the
    // divisor. The shifted remainder needs DATA_W+1 bits for unsigned ops.
    // When the subtraction succeeds, the difference is below the divisor, so
    // its low DATA_W bits hold the whole value.
    logic [DATA_W:0]     rem_sh;
    logic [DATA_W-1:0]   rem_diff;
    logic                rem_ge;
    logic [2*DATA_W-1:0] div_next;
    assign rem_sh   = {acc_q[2*DATA_W-1:DATA_W], acc_q[DATA_W-1]};
    assign rem_diff = rem_sh[DATA_W-1:0] - opnd_q;
    assign rem_ge   = (rem_sh >= {1'b0, opnd_q});
    assign div_next = rem_ge ? {rem_diff, acc_q[DATA_W-2:0], 1'b1}
                             : {rem_sh[DATA_W-1:0], acc_q[DATA_W-2:0], 1'b0};

    // Sign fix-up values used in FIX.
    logic [2*DATA_W-1:0] prod_fix;
    logic [DATA_W-1:0]   quo_fix, rem_fix;
    assign prod_fix = neg_quo_q ? -acc_q : acc_q;
    assign quo_fix  = neg_quo_q ? -acc_q[DATA_W-1:0] : acc_q[DATA_W-1:0];
    assign rem_fix  = neg_rem_q ? -acc_q[2*DATA_W-1:DATA_W]
                                : acc_q[2*DATA_W-1:DATA_W];

`ifdef MULDIV_EARLY_OUT_EN
    // After cnt_q iterations, the low DATA_W-cnt_q bits of the accumulator
    // still hold unconsumed multiplier bits. When they are all zero, the
    // remaining iterations would only shift, so one shift does them all.
    logic [DATA_W-1:0]   mplr_mask;
    logic [CNT_W-1:0]    rem_cnt;
    logic                mplr_zero;
    assign mplr_mask = {DATA_W{1'b1}} >> cnt_q;
    assign rem_cnt   = CNT_W'(DATA_W) - cnt_q;
    assign mplr_zero = ((acc_q[DATA_W-1:0] & mplr_mask) == '0);
`endif

    // Next-state, datapath and strobe logic. Flush is checked first in
    // every busy state.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        opnd_d    = opnd_q;
        is_div_d  = is_div_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        we        = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start && !flush) begin
                    is_div_d  = op[1];
                    neg_quo_d = signed_op & (src_a[DATA_W-1] ^ src_b[DATA_W-1]);
                    neg_rem_d = signed_op & src_a[DATA_W-1];
                    cnt_d     = '0;
                    if (op[1] && (src_b == '0)) begin
                        // Divide by zero skips the iterations.
                        hi_d    = src_a;
                        lo_d    = {DATA_W{1'b1}};
                        state_d = S_DONE;
                    end else if (op[1]) begin
                        opnd_d  = abs_b;
                        acc_d   = {{DATA_W{1'b0}}, abs_a};
                        state_d = S_CALC;
                    end else begin
                        opnd_d  = abs_a;
                        acc_d   = {{DATA_W{1'b0}}, abs_b};
                        state_d = S_CALC;
                    end
                end
            end

            S_CALC: begin
                if (flush) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                    if (is_div_q) begin
                        acc_d = div_next;
                    end else begin
                        acc_d = mul_next;
                    end
                    if (cnt_q == CNT_W'(DATA_W - 1)) begin
                        state_d = S_FIX;
                    end
`ifdef MULDIV_EARLY_OUT_EN
                    if (!is_div_q && mplr_zero) begin
                        acc_d   = acc_q >> rem_cnt;
                        state_d = S_FIX;
                    end
`endif
                end
            end

            S_FIX: begin
                if (flush) begin
                    state_d = S_IDLE;
                end else begin
                    if (is_div_q) begin
                        hi_d = rem_fix;
                        lo_d = quo_fix;
                    end else begin
                        hi_d = prod_fix[2*DATA_W-1:DATA_W];
                        lo_d = prod_fix[DATA_W-1:0];
                    end
                    state_d = S_DONE;
                end
            end

            S_DONE: begin
                we      = ~flush;
                state_d = S_IDLE;
            end

            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers; a reset cancels any operation in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            acc_q     <= '0;
            opnd_q    <= '0;
            is_div_q  <= 1'b0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            opnd_q    <= opnd_d;
            is_div_q  <= is_div_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
        end
    end

    assign busy      = (state_q != S_IDLE);
    assign stall_req = busy & (hilo_use_id | start);
    assign hilo_we   = we;
    assign hi_out    = hi_q;
    assign lo_out    = lo_q;

endmodule

// File: tb/tb_muldiv_seq_ctrl.sv
// Testbench for muldiv_seq_ctrl. It applies a vector table through a
// scoreboard queue, then runs hand-written sequences for flush, stall,
// back-to-back operations and reset.
module tb_muldiv_seq_ctrl;
    localparam int W = 32;

    logic          clk = 1'b0;
    logic          rst, start, flush, hilo_use_id;
    logic [1:0]    op;
    logic [W-1:0]  src_a, src_b;
    logic          busy, stall_req, hilo_we;
    logic [W-1:0]  hi_out, lo_out;

    muldiv_seq_ctrl #(.DATA_W(W)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op),
        .src_a(src_a), .src_b(src_b), .flush(flush),
        .hilo_use_id(hilo_use_id), .busy(busy), .stall_req(stall_req),
        .hilo_we(hilo_we), .hi_out(hi_out), .lo_out(lo_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a, b, hi, lo;
    } vec_t;

    typedef struct {
        logic [31:0] hi, lo;
        int          lat, t0;
    } exp_t;

    exp_t sbq[$];
    exp_t ent;
    vec_t vt[13];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    int   t0    = 0;
    logic [31:0] last_hi, last_lo;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, want);
        end
    endtask

    // Edges from the start edge E0 to the edge at which HI/LO are captured.
    function automatic int exp_lat(input logic [1:0] o, input logic [31:0] b);
        if (o[1]) return (b == 0) ? 1 : 34;
`ifdef MULDIV_EARLY_OUT_EN
        begin
            logic [31:0] m;
            int          n;
            m = (!o[0] && b[31]) ? -b : b;
            if (m == 0) return 3;
            n = 0;
            for (int i = 0; i < 32; i++) if (m[i]) n = i;
            return (n == 31) ? 34 : n + 4;
        end
`else
        return 34;
`endif
    endfunction

    // Write monitor: each strobe pops one expected result.
    always @(negedge clk) begin
        if (hilo_we) begin
            if (sbq.size() == 0) begin
                check("unexpected_write", 64'd1, 64'd0);
            end else begin
                ent = sbq.pop_front();
                check("hi", hi_out, ent.hi);
                check("lo", lo_out, ent.lo);
                check("latency", 64'(cyc + 1 - ent.t0), 64'(ent.lat));
            end
        end
    end

    // Wait (bounded) at the negedge until the sequencer is idle.
    task automatic wait_idle();
        int g = 0;
        do begin
            @(negedge clk);
            g++;
        end while (busy && g < 200);
        if (busy) check("idle_timeout", 64'd1, 64'd0);
    endtask

    // Drive an op at the negedge and release start after edge E0.
    task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        op = o; src_a = a; src_b = b; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        t0 = cyc;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; flush = 1'b0; hilo_use_id = 1'b0;
        op = 2'b00; src_a = '0; src_b = '0;

        vt[0]  = '{2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
        vt[1]  = '{2'b00, 32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1};
        vt[2]  = '{2'b10, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
        vt[3]  = '{2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
        vt[4]  = '{2'b11, 32'h00000064, 32'h00000000, 32'h00000064, 32'hFFFFFFFF};
        vt[5]  = '{2'b01, 32'h00000007, 32'h00000003, 32'h00000000, 32'h00000015};
        vt[6]  = '{2'b00, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
        vt[7]  = '{2'b11, 32'hFFFFFFFF, 32'h00000003, 32'h00000000, 32'h55555555};
        vt[8]  = '{2'b10, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
        vt[9]  = '{2'b00, 32'h12345678, 32'h00000000, 32'h00000000, 32'h00000000};
        vt[10] = '{2'b11, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'h00000000};
        vt[11] = '{2'b10, 32'hFFFFFFFB, 32'h00000000, 32'hFFFFFFFB, 32'hFFFFFFFF};
        vt[12] = '{2'b01, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000};

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_stall", stall_req, 0);
        check("rst_we", hilo_we, 0);
        check("rst_hi", hi_out, 0);
        check("rst_lo", lo_out, 0);
        rst = 1'b0;
        @(negedge clk);

        // Vector table through the scoreboard
        for (int i = 0; i < 13; i++) begin
            issue(vt[i].op, vt[i].a, vt[i].b);
            sbq.push_back('{vt[i].hi, vt[i].lo, exp_lat(vt[i].op, vt[i].b), t0});
            wait_idle();
            check("pending", 64'(sbq.size()), 0);
            last_hi = vt[i].hi; last_lo = vt[i].lo;
        end

        // Flush in CALC: back to idle, HI/LO untouched, no write
        issue(2'b00, 32'd5, 32'hFFFFFFFF);
        repeat (9) @(posedge clk);
        #1 flush = 1'b1;
        @(posedge clk); #1 flush = 1'b0;
        @(negedge clk);
        check("flush_calc_busy", busy, 0);
        check("flush_calc_hi", hi_out, last_hi);
        check("flush_calc_lo", lo_out, last_lo);
        repeat (40) @(negedge clk);
        check("flush_calc_idle", busy, 0);

        // Flush in DONE: strobe suppressed, FIX already loaded HI/LO
        issue(2'b11, 32'd100, 32'd7);
        repeat (33) @(posedge clk);
        #1 flush = 1'b1;
        @(negedge clk);
        check("flush_done_busy", busy, 1);
        check("flush_done_we", hilo_we, 0);
        @(posedge clk); #1 flush = 1'b0;
        @(negedge clk);
        check("flush_done_idle", busy, 0);
        check("flush_done_hi", hi_out, 32'd2);
        check("flush_done_lo", lo_out, 32'd14);

        // Flush in IDLE blocks start
        op = 2'b01; src_a = 32'd3; src_b = 32'd3; start = 1'b1; flush = 1'b1;
        @(posedge clk); #1 start = 1'b0; flush = 1'b0;
        @(negedge clk);
        check("flush_idle_blocks", busy, 0);

        // Stall behaviour
        begin
            logic ok = 1'b1;
            int   g  = 0;
            issue(2'b10, 32'hFFFFFFF9, 32'd2);
            sbq.push_back('{32'hFFFFFFFF, 32'hFFFFFFFD, 34, t0});
            @(negedge clk);
            check("nostall_busy", busy, 1);
            check("nostall_req", stall_req, 0);
            hilo_use_id = 1'b1;
            @(negedge clk);
            while (busy && g < 200) begin
                if (stall_req !== 1'b1) ok = 1'b0;
                @(negedge clk);
                g++;
            end
            check("stall_through_done", ok, 1);
            check("stall_idle_busy", busy, 0);
            check("stall_idle_drop", stall_req, 0);
            hilo_use_id = 1'b0;
            check("stall_pending", 64'(sbq.size()), 0);
        end

        // Back-to-back: start held across the op, re-sampled in IDLE
        begin
            int g = 0;
            int l = exp_lat(2'b01, 32'd3);
            op = 2'b01; src_a = 32'd7; src_b = 32'd3; start = 1'b1;
            @(posedge clk); #1;
            t0 = cyc;
            sbq.push_back('{32'd0, 32'd21, l, t0});
            sbq.push_back('{32'd0, 32'd21, l, t0 + l + 1});
            @(negedge clk);
            check("stall_held_start", stall_req, 1);
            while (busy && g < 200) begin
                @(negedge clk);
                g++;
            end
            @(posedge clk); #1 start = 1'b0;
            wait_idle();
            check("b2b_pending", 64'(sbq.size()), 0);
        end

        // Reset in the middle of a divide
        issue(2'b10, 32'd1000, 32'd3);
        hilo_use_id = 1'b1;
        repeat (4) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_stall", stall_req, 0);
        check("mid_rst_we", hilo_we, 0);
        check("mid_rst_hi", hi_out, 0);
        check("mid_rst_lo", lo_out, 0);
        hilo_use_id = 1'b0;
        repeat (45) @(negedge clk);
        check("mid_rst_idle", busy, 0);
        check("final_pending", 64'(sbq.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
